// File: rtl/execute_stage.sv
// RV32IM execute stage: single-cycle ALU/multiply, iterative restoring divider,
// and the registered EX/MEM boundary.
module execute_stage #(
  parameter int unsigned XLEN       = 32,
  parameter bit          DIV_ENABLE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [4:0]      alu_control,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic [XLEN-1:0] store_data_in,
  input  logic [4:0]      rd_in,
  input  logic            load_in,
  input  logic            store_in,
  input  logic            jalr_in,
  input  logic            next_sel_in,
  input  logic            branch_in,
  input  logic            reg_write_en_in,
  input  logic [1:0]      mem_to_reg_in,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd_out,
  output logic            load,
  output logic            store,
  output logic            jalr,
  output logic            next_sel,
  output logic            reg_write_en,
  output logic [1:0]      mem_to_reg,
  output logic            branch_taken
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam int unsigned ProdW = 2 * XLEN;

  localparam logic [4:0] OpAdd    = 5'd0;
  localparam logic [4:0] OpSub    = 5'd1;
  localparam logic [4:0] OpSll    = 5'd2;
  localparam logic [4:0] OpSlt    = 5'd3;
  localparam logic [4:0] OpSltu   = 5'd4;
  localparam logic [4:0] OpXor    = 5'd5;
  localparam logic [4:0] OpSrl    = 5'd6;
  localparam logic [4:0] OpSra    = 5'd7;
  localparam logic [4:0] OpOr     = 5'd8;
  localparam logic [4:0] OpAnd    = 5'd9;
  localparam logic [4:0] OpPassB  = 5'd10;
  localparam logic [4:0] OpMul    = 5'd11;
  localparam logic [4:0] OpMulh   = 5'd12;
  localparam logic [4:0] OpMulhsu = 5'd13;
  localparam logic [4:0] OpMulhu  = 5'd14;
  localparam logic [4:0] OpDiv    = 5'd15;
  localparam logic [4:0] OpDivu   = 5'd16;
  localparam logic [4:0] OpRem    = 5'd17;
  localparam logic [4:0] OpRemu   = 5'd18;
  localparam logic [4:0] OpBeq    = 5'd19;
  localparam logic [4:0] OpBne    = 5'd20;
  localparam logic [4:0] OpBlt    = 5'd21;
  localparam logic [4:0] OpBge    = 5'd22;
  localparam logic [4:0] OpBltu   = 5'd23;
  localparam logic [4:0] OpBgeu   = 5'd24;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [XLEN-1:0]   quo_q, rem_q, dvs_q, dvd_q;
  logic              qneg_q, rneg_q, is_rem_q, div_zero_q;

  logic              out_valid_q, load_q, store_q, jalr_q, next_sel_q;
  logic              reg_write_en_q, branch_taken_q;
  logic [1:0]        mem_to_reg_q;
  logic [XLEN-1:0]   alu_result_q, store_data_q;
  logic [4:0]        rd_q;

  logic [XLEN-1:0]   alu_c, div_res_c, result_c;
  logic              cond_c, is_div_c, commit_c, signed_div_c;
  logic [4:0]        shamt_c;
  logic [ProdW-1:0]  mul_ss_c, mul_su_c, mul_uu_c;
  logic [XLEN:0]     trial_c;
  logic              trial_ge_c;
  logic [XLEN-1:0]   q_fix_c, r_fix_c;

  // Single-cycle ALU, multiplier and branch compare
  always_comb begin
    alu_c    = '0;
    cond_c   = 1'b0;
    shamt_c  = opb[4:0];
    // Operands widened with the required signedness; low 2*XLEN bits are exact.
    mul_ss_c = {{XLEN{opa[XLEN-1]}}, opa} * {{XLEN{opb[XLEN-1]}}, opb};
    mul_su_c = {{XLEN{opa[XLEN-1]}}, opa} * {{XLEN{1'b0}}, opb};
    mul_uu_c = {{XLEN{1'b0}}, opa} * {{XLEN{1'b0}}, opb};
    case (alu_control)
      OpBeq:  cond_c = (opa == opb);
      OpBne:  cond_c = (opa != opb);
      OpBlt:  cond_c = ($signed(opa) < $signed(opb));
      OpBge:  cond_c = ($signed(opa) >= $signed(opb));
      OpBltu: cond_c = (opa < opb);
      OpBgeu: cond_c = (opa >= opb);
      default: cond_c = 1'b0;
    endcase
    case (alu_control)
      OpAdd:    alu_c = opa + opb;
      OpSub:    alu_c = opa - opb;
      OpSll:    alu_c = opa << shamt_c;
      OpSlt:    alu_c = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
      OpSltu:   alu_c = {{(XLEN-1){1'b0}}, (opa < opb)};
      OpXor:    alu_c = opa ^ opb;
      OpSrl:    alu_c = opa >> shamt_c;
      OpSra:    alu_c = XLEN'($signed(opa) >>> shamt_c);
      OpOr:     alu_c = opa | opb;
      OpAnd:    alu_c = opa & opb;
      OpPassB:  alu_c = opb;
      OpMul:    alu_c = mul_uu_c[XLEN-1:0];
      OpMulh:   alu_c = mul_ss_c[ProdW-1:XLEN];
      OpMulhsu: alu_c = mul_su_c[ProdW-1:XLEN];
      OpMulhu:  alu_c = mul_uu_c[ProdW-1:XLEN];
      OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu:
                alu_c = {{(XLEN-1){1'b0}}, cond_c};
      default:  alu_c = '0;
    endcase
  end

  // Divider step, sign correction and handshake
  always_comb begin
    is_div_c     = DIV_ENABLE && (alu_control >= OpDiv) && (alu_control <= OpRemu);
    signed_div_c = (alu_control == OpDiv) || (alu_control == OpRem);
    trial_c      = {rem_q, quo_q[XLEN-1]};
    trial_ge_c   = (trial_c >= {1'b0, dvs_q});
    q_fix_c      = qneg_q ? (XLEN'(0) - quo_q) : quo_q;
    r_fix_c      = rneg_q ? (XLEN'(0) - rem_q) : rem_q;
    // Divide by zero bypasses the datapath; overflow falls out of the magnitudes.
    if (div_zero_q) begin
      q_fix_c = '1;
      r_fix_c = dvd_q;
    end
    div_res_c = is_rem_q ? r_fix_c : q_fix_c;

    stall = 1'b0;
    case (state_q)
      IDLE:    stall = in_valid && is_div_c && !flush;
      BUSY:    stall = !flush;
      default: stall = 1'b0;
    endcase

    commit_c = in_valid && !flush &&
               (((state_q == IDLE) && !is_div_c) || (state_q == DONE));
    result_c = (state_q == DONE) ? div_res_c : alu_c;
  end

  // EX/MEM registers and divider FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      quo_q          <= '0;
      rem_q          <= '0;
      dvs_q          <= '0;
      dvd_q          <= '0;
      qneg_q         <= 1'b0;
      rneg_q         <= 1'b0;
      is_rem_q       <= 1'b0;
      div_zero_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      load_q         <= 1'b0;
      store_q        <= 1'b0;
      jalr_q         <= 1'b0;
      next_sel_q     <= 1'b0;
      reg_write_en_q <= 1'b0;
      branch_taken_q <= 1'b0;
      mem_to_reg_q   <= '0;
      alu_result_q   <= '0;
      store_data_q   <= '0;
      rd_q           <= '0;
    end else begin
      out_valid_q    <= commit_c;
      load_q         <= commit_c && load_in;
      store_q        <= commit_c && store_in;
      jalr_q         <= commit_c && jalr_in;
      next_sel_q     <= commit_c && next_sel_in;
      reg_write_en_q <= commit_c && reg_write_en_in;
      branch_taken_q <= commit_c && branch_in && cond_c;
      mem_to_reg_q   <= commit_c ? mem_to_reg_in : 2'b00;
      if (commit_c) begin
        alu_result_q <= result_c;
        store_data_q <= store_data_in;
        rd_q         <= rd_in;
      end

      case (state_q)
        IDLE: begin
          if (in_valid && !flush && is_div_c) begin
            quo_q      <= (signed_div_c && opa[XLEN-1]) ? (XLEN'(0) - opa) : opa;
            dvs_q      <= (signed_div_c && opb[XLEN-1]) ? (XLEN'(0) - opb) : opb;
            rem_q      <= '0;
            dvd_q      <= opa;
            qneg_q     <= signed_div_c && (opa[XLEN-1] ^ opb[XLEN-1]);
            rneg_q     <= signed_div_c && opa[XLEN-1];
            is_rem_q   <= (alu_control == OpRem) || (alu_control == OpRemu);
            div_zero_q <= (opb == '0);
            cnt_q      <= CntW'(XLEN - 1);
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            rem_q <= trial_ge_c ? XLEN'(trial_c - {1'b0, dvs_q}) : trial_c[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], trial_ge_c};
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == '0) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign alu_result   = alu_result_q;
  assign store_data   = store_data_q;
  assign rd_out       = rd_q;
  assign load         = load_q;
  assign store        = store_q;
  assign jalr         = jalr_q;
  assign next_sel     = next_sel_q;
  assign reg_write_en = reg_write_en_q;
  assign mem_to_reg   = mem_to_reg_q;
  assign branch_taken = branch_taken_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: ALU, multiply, branch,
// divider latency/special cases, flush and asynchronous reset.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush;
  logic [4:0]  alu_control;
  logic [31:0] opa, opb, store_data_in;
  logic [4:0]  rd_in;
  logic        load_in, store_in, jalr_in, next_sel_in, branch_in, reg_write_en_in;
  logic [1:0]  mem_to_reg_in;
  logic        stall, out_valid;
  logic [31:0] alu_result, store_data;
  logic [4:0]  rd_out;
  logic        load, store, jalr, next_sel, reg_write_en, branch_taken;
  logic [1:0]  mem_to_reg;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .alu_control(alu_control), .opa(opa), .opb(opb),
    .store_data_in(store_data_in), .rd_in(rd_in),
    .load_in(load_in), .store_in(store_in), .jalr_in(jalr_in),
    .next_sel_in(next_sel_in), .branch_in(branch_in),
    .reg_write_en_in(reg_write_en_in), .mem_to_reg_in(mem_to_reg_in),
    .stall(stall), .out_valid(out_valid), .alu_result(alu_result),
    .store_data(store_data), .rd_out(rd_out), .load(load), .store(store),
    .jalr(jalr), .next_sel(next_sel), .reg_write_en(reg_write_en),
    .mem_to_reg(mem_to_reg), .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_control = op;
    opa         = a;
    opb         = b;
    in_valid    = 1'b1;
  endtask

  task automatic single(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    drive(op, a, b);
    #1;
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk(tag, alu_result, exp);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic divide(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    drive(op, a, b);
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(posedge clk); #1;
      if (stall) chk({tag, "_busy_valid"}, 32'(out_valid), 32'd0);
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'd33);
    chk({tag, "_pre_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk(tag, alu_result, exp);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; alu_control = '0;
    opa = '0; opb = '0; store_data_in = '0; rd_in = '0;
    load_in = 1'b0; store_in = 1'b0; jalr_in = 1'b0; next_sel_in = 1'b0;
    branch_in = 1'b0; reg_write_en_in = 1'b0; mem_to_reg_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", alu_result, 32'd0);
    chk("rst_regwe", 32'(reg_write_en), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // pass-through fields with an ADD overflow
    store_data_in = 32'hDEADBEEF; rd_in = 5'd5; reg_write_en_in = 1'b1; mem_to_reg_in = 2'd2;
    single("add_ovf", 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000);
    chk("pt_store_data", store_data, 32'hDEADBEEF);
    chk("pt_rd", 32'(rd_out), 32'd5);
    chk("pt_regwe", 32'(reg_write_en), 32'd1);
    chk("pt_m2r", 32'(mem_to_reg), 32'd2);

    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bubble_valid", 32'(out_valid), 32'd0);
    chk("bubble_regwe", 32'(reg_write_en), 32'd0);
    chk("bubble_m2r", 32'(mem_to_reg), 32'd0);
    reg_write_en_in = 1'b0; mem_to_reg_in = '0;

    single("sub",    5'd1,  32'h0,        32'h1,        32'hFFFFFFFF);
    single("sll",    5'd2,  32'h1,        32'h3F,       32'h80000000);
    single("slt",    5'd3,  32'hFFFFFFFF, 32'h1,        32'h1);
    single("sltu",   5'd4,  32'hFFFFFFFF, 32'h1,        32'h0);
    single("srl",    5'd6,  32'h80000000, 32'h4,        32'h08000000);
    single("sra",    5'd7,  32'h80000000, 32'h4,        32'hF8000000);
    single("passb",  5'd10, 32'h12345678, 32'hABCDE000, 32'hABCDE000);
    single("mulhu",  5'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    single("mulh",   5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    single("mul",    5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    single("mulhsu", 5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    single("op25",   5'd25, 32'h5,        32'h6,        32'h0);

    branch_in = 1'b1;
    single("blt", 5'd21, 32'hFFFFFFFF, 32'h1, 32'h1);
    chk("blt_taken", 32'(branch_taken), 32'd1);
    single("bgeu", 5'd24, 32'hFFFFFFFF, 32'h1, 32'h1);
    chk("bgeu_taken", 32'(branch_taken), 32'd1);
    single("beq", 5'd19, 32'h3, 32'h4, 32'h0);
    chk("beq_taken", 32'(branch_taken), 32'd0);
    branch_in = 1'b0;

    divide("div_m7_2",  5'd15, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD);
    divide("rem_m7_2",  5'd17, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF);
    divide("divu_x_0",  5'd16, 32'h00001234, 32'h0,        32'hFFFFFFFF);
    divide("rem_5_0",   5'd17, 32'h5,        32'h0,        32'h5);
    divide("div_ovf",   5'd15, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    divide("rem_ovf",   5'd17, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    divide("divu_100_7",5'd16, 32'd100,      32'd7,        32'd14);
    divide("remu_100_7",5'd18, 32'd100,      32'd7,        32'd2);

    // flush on the tenth BUSY cycle
    drive(5'd15, 32'd100, 32'd7);
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    chk("flush_busy_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_stall_drop", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    single("after_flush_add", 5'd0, 32'd2, 32'd3, 32'd5);

    // asynchronous reset in the middle of a divide
    drive(5'd16, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("arst_result", alu_result, 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    @(negedge clk) rst = 1'b0;
    single("after_rst_add", 5'd0, 32'd10, 32'd20, 32'd30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- RV32IM execute stage, directly downstream of the decode stage; consumes decode's registered control and muxed operands.
- Computes the ALU/M-extension result and the branch condition, then registers everything into the EX/MEM boundary.
- Single-cycle ALU and multiply; iterative divide/remainder runs under an FSM that stalls upstream via `stall`.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DIV_ENABLE, 1, when 0 the divider FSM is omitted and div/rem codes give 0 with single-cycle latency.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  decode output holds a live instruction
- flush  in  1  kill the in-flight instruction and abort a divide
- alu_control  in  5  operation code (see Behaviour)
- opa  in  32  muxed operand A from decode
- opb  in  32  muxed operand B from decode
- store_data_in  in  32  rs2 value for stores
- rd_in  in  5  destination register
- load_in, store_in, jalr_in, next_sel_in, branch_in, reg_write_en_in  in  1 each  control pass-through
- mem_to_reg_in  in  2  writeback select
- stall  out  1  combinational; upstream holds its registers while high
- out_valid  out  1  EX/MEM entry is valid
- alu_result  out  32  registered result
- store_data  out  32  registered
- rd_out  out  5  registered
- load, store, jalr, next_sel, reg_write_en  out  1 each  registered pass-through
- mem_to_reg  out  2  registered
- branch_taken  out  1  registered; branch_in AND compare true

Behaviour:
- Reset: every output register is 0, FSM goes to IDLE, divider counter is 0.
- Bubble: if in_valid=0 or flush=1 at a clock edge, the edge loads out_valid=0 and every control output 0. Data outputs may hold their previous values.
- Opcodes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (LUI).
  - 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU.
  - 15 DIV, 16 DIVU, 17 REM, 18 REMU.
  - 19 BEQ, 20 BNE, 21 BLT, 22 BGE, 23 BLTU, 24 BGEU; compare ops give alu_result = {31'b0, cond}.
  - Codes 25-31 give 0.
- Shift amount is opb[4:0]. MULH variants return the upper 32 bits of the 64-bit product with the stated signedness.
- Non-divide ops: single-cycle. Inputs present at edge N appear on the outputs after edge N with out_valid=1. stall stays 0.
- Divide FSM states IDLE, BUSY, DONE:
  - IDLE with in_valid and a div/rem code, and no flush: stall=1 combinationally. At the edge, latch operand magnitudes and signs and go to BUSY with count=31.
  - BUSY: one restoring-division step per cycle, stall=1, count decrements. When count reaches 0, go to DONE (32 BUSY cycles).
  - DONE: stall=0. The edge loads the sign-corrected result with out_valid=1 and returns to IDLE; upstream advances on that same edge.
  - Total latency: accept edge to result edge is 34 edges.
  - While in BUSY, out_valid is 0 on every edge.
- Divide special cases (RISC-V semantics, same latency):
  - Divide by zero: quotient=0xFFFFFFFF, remainder=dividend.
  - Signed overflow 0x80000000/-1: quotient=0x80000000, remainder=0.
- flush in BUSY or DONE: FSM returns to IDLE at the next edge, stall drops immediately (combinational), no result is produced.
- Async reset mid-divide: FSM goes to IDLE at once and all outputs clear.
- Inputs must stay stable while stall=1; changes during that time are ignored.

Test Plan:
- ADD opa=0x7FFFFFFF, opb=1 -> next edge alu_result=0x80000000, out_valid=1. SRA 0x80000000 by 4 -> 0xF8000000.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MUL -> 0x00000001.
- DIV -7/2 -> stall high for exactly 33 cycles, result -3 (0xFFFFFFFD) with out_valid on the 34th edge. REM -7/2 -> 0xFFFFFFFF.
- DIVU x/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000. REM of the same -> 0.
- BLT opa=-1, opb=1 with branch_in=1 -> branch_taken=1, alu_result=1. BGEU on the same operands -> branch_taken=1. BEQ 3,4 -> 0.
- Flush on BUSY cycle 10 -> stall drops that cycle, out_valid=0, the next ADD completes normally. Async rst mid-divide -> all outputs 0 immediately.
